// File: rtl/audio_dac_tx_if.sv
// Sample-pair stream into the DAC transmitter: one left/right pair per valid/ready beat.
interface audio_dac_tx_if #(
   parameter int DATA_WIDTH = 16
);
   logic                  s_valid;
   logic                  s_ready;
   logic [DATA_WIDTH-1:0] s_left;
   logic [DATA_WIDTH-1:0] s_right;

   modport master (output s_valid, output s_left, output s_right, input s_ready);
   modport slave  (input s_valid, input s_left, input s_right, output s_ready);
endinterface

// File: rtl/audio_dac_tx.sv
// I2S playback transmitter: buffers stereo pairs and shifts them onto DACDAT,
// timed by codec-mastered BCLK/DACLRCK that are resynchronised onto clk.
//
// state     | meaning
// WAIT_SYNC | after reset; idle until the first DACLRCK falling edge
// LEFT      | shifting the left word, MSB first, then zero padding
// RIGHT     | shifting the held right word, MSB first, then zero padding
module audio_dac_tx #(
   parameter int DATA_WIDTH = 16,
   parameter int FIFO_DEPTH = 4
) (
   input  logic                          clk,
   input  logic                          reset,
   audio_dac_tx_if.slave                 s_bus,
   input  logic                          audio_BCLK,
   input  logic                          audio_DACLRCK,
   output logic                          audio_DACDAT,
   output logic                          underrun,
   output logic [$clog2(FIFO_DEPTH):0]   level
);

   localparam int AW = $clog2(FIFO_DEPTH);
   localparam int CW = $clog2(DATA_WIDTH + 1);
   localparam logic [AW:0]   FULL_LVL = FIFO_DEPTH[AW:0];
   localparam logic [CW-1:0] CNT_FULL = DATA_WIDTH[CW-1:0];

   typedef enum logic [1:0] {WAIT_SYNC, LEFT, RIGHT} state_t;

   state_t state, state_nxt;

   logic bclk_s1, bclk_s2, bclk_s3;
   logic lrck_s1, lrck_s2, lrck_s3;
   logic [1:0] warm_cnt;
   logic edge_en, bclk_fall, lrck_fall, lrck_rise, frame_start;

   logic [DATA_WIDTH-1:0] mem_l [FIFO_DEPTH];
   logic [DATA_WIDTH-1:0] mem_r [FIFO_DEPTH];
   logic [AW-1:0] wr_ptr, rd_ptr;
   logic fifo_empty, push, pop;

   logic [DATA_WIDTH-1:0] shift_q, shift_nxt;
   logic [DATA_WIDTH-1:0] hold_r_q, hold_r_nxt;
   logic [CW-1:0] cnt_q, cnt_nxt;
   logic dat_nxt;

   // lrck_s3 tracks the pin freely during warm-up, then only on BCLK falls,
   // so LRCK transitions are always judged at a bit boundary.
   always_ff @(posedge clk) begin
      if (reset) begin
         bclk_s1  <= 1'b0;
         bclk_s2  <= 1'b0;
         bclk_s3  <= 1'b0;
         lrck_s1  <= 1'b0;
         lrck_s2  <= 1'b0;
         lrck_s3  <= 1'b0;
         warm_cnt <= 2'd3;
      end else begin
         bclk_s1 <= audio_BCLK;
         bclk_s2 <= bclk_s1;
         bclk_s3 <= bclk_s2;
         lrck_s1 <= audio_DACLRCK;
         lrck_s2 <= lrck_s1;
         if (!edge_en || bclk_fall) begin
            lrck_s3 <= lrck_s2;
         end
         if (warm_cnt != 2'd0) begin
            warm_cnt <= warm_cnt - 2'd1;
         end
      end
   end

   assign edge_en     = (warm_cnt == 2'd0);
   assign bclk_fall   = edge_en & bclk_s3 & ~bclk_s2;
   assign lrck_fall   = bclk_fall & lrck_s3 & ~lrck_s2;
   assign lrck_rise   = bclk_fall & ~lrck_s3 & lrck_s2;
   assign frame_start = lrck_fall & ~reset;

   assign fifo_empty    = (level == '0);
   assign s_bus.s_ready = ~reset & (level != FULL_LVL);
   assign push          = s_bus.s_valid & s_bus.s_ready;
   assign pop           = frame_start & ~fifo_empty;
   assign underrun      = frame_start & fifo_empty;

   always_ff @(posedge clk) begin
      if (push) begin
         mem_l[wr_ptr] <= s_bus.s_left;
         mem_r[wr_ptr] <= s_bus.s_right;
      end
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         wr_ptr <= '0;
         rd_ptr <= '0;
         level  <= '0;
      end else begin
         if (push) begin
            wr_ptr <= wr_ptr + 1'b1;
         end
         if (pop) begin
            rd_ptr <= rd_ptr + 1'b1;
         end
         case ({push, pop})
            2'b10:   level <= level + 1'b1;
            2'b01:   level <= level - 1'b1;
            default: level <= level;
         endcase
      end
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         state        <= WAIT_SYNC;
         shift_q      <= '0;
         hold_r_q     <= '0;
         cnt_q        <= '0;
         audio_DACDAT <= 1'b0;
      end else begin
         state        <= state_nxt;
         shift_q      <= shift_nxt;
         hold_r_q     <= hold_r_nxt;
         cnt_q        <= cnt_nxt;
         audio_DACDAT <= dat_nxt;
      end
   end

   // Left word goes straight into the shifter; only right needs holding for later.
   always_comb begin
      state_nxt  = state;
      shift_nxt  = shift_q;
      hold_r_nxt = hold_r_q;
      cnt_nxt    = cnt_q;
      dat_nxt    = audio_DACDAT;
      if (frame_start) begin
         state_nxt  = LEFT;
         shift_nxt  = pop ? mem_l[rd_ptr] : '0;
         hold_r_nxt = pop ? mem_r[rd_ptr] : '0;
         cnt_nxt    = CNT_FULL;
         dat_nxt    = 1'b0;
      end else if (lrck_rise && state != WAIT_SYNC) begin
         state_nxt = RIGHT;
         shift_nxt = hold_r_q;
         cnt_nxt   = CNT_FULL;
         dat_nxt   = 1'b0;
      end else if (bclk_fall && state != WAIT_SYNC) begin
         if (cnt_q != '0) begin
            dat_nxt   = shift_q[DATA_WIDTH-1];
            shift_nxt = {shift_q[DATA_WIDTH-2:0], 1'b0};
            cnt_nxt   = cnt_q - 1'b1;
         end else begin
            dat_nxt = 1'b0;
         end
      end
   end

endmodule
